mem_stack_ctrl: RTL and testbench

Sequencer and arbiter in front of the data-memory stage. Shares the memory port between the pipeline's memory-stage requests and the two-word interrupt context save (push PC, push flags) and RTI restore (pop flags, pop PC). Stalls the pipeline while a sequence runs. Tracks stack occupancy so stack misuse can be detected.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/stack_depth_tracker.sv | 56 +++++
 rtl/mem_stack_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_stack_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory stack controller.
// The optional stack guard is enabled with the STACK_GUARD_EN macro.
package mem_pkg;

  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_FLAG_W      = 3;
  localparam int DEF_DEPTH_W     = 11;
  localparam int DEF_STACK_DEPTH = 2047;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_PC,
    PUSH_FLAGS,
    POP_FLAGS,
    POP_PC
  } state_t;

  // Flags occupy the low bits of a stack word; the upper bits are pushed as zero.
  function automatic logic [DEF_DATA_W-1:0] zext_flags(input logic [DEF_FLAG_W-1:0] flags);
    return {{(DEF_DATA_W-DEF_FLAG_W){1'b0}}, flags};
  endfunction

endpackage

// File: rtl/stack_depth_tracker.sv
// Stack occupancy counter. With STACK_GUARD_EN it also suppresses overflow and
// underflow accesses and raises a sticky fault.
module stack_depth_tracker
  import mem_pkg::*;
#(
  parameter int DEPTH_W     = DEF_DEPTH_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_req,
  input  logic               pop_req,
  output logic               push_ok,
  output logic               pop_ok,
  output logic [DEPTH_W-1:0] depth
`ifdef STACK_GUARD_EN
  ,
  output logic               fault
`endif
);

  logic [DEPTH_W-1:0] depth_q;

`ifdef STACK_GUARD_EN
  localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);

  logic fault_q;

  assign push_ok = push_req && (depth_q != FULL);
  assign pop_ok  = pop_req && (depth_q != '0);
  assign fault   = fault_q;

  always_ff @(posedge clk) begin
    if (rst)
      fault_q <= 1'b0;
    else if ((push_req && !push_ok) || (pop_req && !pop_ok))
      fault_q <= 1'b1;
  end
`else
  assign push_ok = push_req;
  assign pop_ok  = pop_req;
`endif

  // Push and pop are mutually exclusive upstream; counter wraps modulo 2^DEPTH_W.
  always_ff @(posedge clk) begin
    if (rst)
      depth_q <= '0;
    else if (push_ok)
      depth_q <= depth_q + DEPTH_W'(1);
    else if (pop_ok)
      depth_q <= depth_q - DEPTH_W'(1);
  end

  assign depth = depth_q;

endmodule

// File: rtl/mem_stack_ctrl.sv
// Memory-port arbiter: pipeline requests vs. interrupt context save / RTI restore.
// Optional STACK_GUARD_EN adds overflow/underflow suppression and stack_fault.
module mem_stack_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FLAG_W      = DEF_FLAG_W,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int DEPTH_W     = DEF_DEPTH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_mem_push,
  input  logic               ex_mem_pop,
  input  logic [ADDR_W-1:0]  ex_address,
  input  logic [DATA_W-1:0]  ex_write_data,
  input  logic               int_req,
  input  logic [ADDR_W-1:0]  int_pc,
  input  logic [FLAG_W-1:0]  int_flags,
  input  logic               rti_req,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               memory_read,
  output logic               memory_write,
  output logic               memory_push,
  output logic               memory_pop,
  output logic [ADDR_W-1:0]  address,
  output logic [DATA_W-1:0]  write_data,
  output logic               stall,
  output logic               int_ack,
  output logic               rti_ack,
  output logic               restore_valid,
  output logic [ADDR_W-1:0]  restore_pc,
  output logic [FLAG_W-1:0]  restore_flags,
  output logic [DEPTH_W-1:0] stack_depth
`ifdef STACK_GUARD_EN
  ,
  output logic               stack_fault
`endif
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] pc_q;
  logic [FLAG_W-1:0] flags_q;
  logic              latch_int;
  logic              push_req, pop_req;

  stack_depth_tracker #(
    .DEPTH_W    (DEPTH_W),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .push_req(push_req),
    .pop_req (pop_req),
    .push_ok (memory_push),
    .pop_ok  (memory_pop),
    .depth   (stack_depth)
`ifdef STACK_GUARD_EN
    ,
    .fault   (stack_fault)
`endif
  );

  assign stall = (state != IDLE);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves
    // a signal unassigned, which would otherwise infer a latch.
    next_state   = state;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    push_req     = 1'b0;
    pop_req      = 1'b0;
    address      = '0;
    write_data   = '0;
    int_ack      = 1'b0;
    rti_ack      = 1'b0;
    latch_int    = 1'b0;

    unique case (state)
      IDLE: begin
        // An accepted RTI owns this cycle's memory port; an interrupt does not.
        if (int_req || !rti_req) begin
          memory_read  = ex_mem_read;
          memory_write = ex_mem_write;
          push_req     = ex_mem_push;
          pop_req      = ex_mem_pop && !ex_mem_push;
          address      = ex_address;
          write_data   = ex_write_data;
        end
        if (int_req) begin
          latch_int  = 1'b1;
          next_state = PUSH_PC;
        end else if (rti_req) begin
          next_state = POP_FLAGS;
        end
      end
      PUSH_PC: begin
        push_req   = 1'b1;
        write_data = DATA_W'(pc_q);
        next_state = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        push_req   = 1'b1;
        write_data = zext_flags(flags_q);
        int_ack    = 1'b1;
        next_state = IDLE;
      end
      POP_FLAGS: begin
        pop_req    = 1'b1;
        next_state = POP_PC;
      end
      POP_PC: begin
        pop_req    = 1'b1;
        rti_ack    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pc_q          <= '0;
      flags_q       <= '0;
      restore_pc    <= '0;
      restore_flags <= '0;
      restore_valid <= 1'b0;
    end else begin
      state         <= next_state;
      restore_valid <= (state == POP_PC);
      if (latch_int) begin
        pc_q    <= int_pc;
        flags_q <= int_flags;
      end
      if (state == POP_FLAGS)
        restore_flags <= rd_data[FLAG_W-1:0];
      if (state == POP_PC)
        restore_pc <= rd_data[ADDR_W-1:0];
    end
  end

endmodule

// File: tb/tb_mem_stack_ctrl.sv
// Directed bench for mem_stack_ctrl with a push-data and restore scoreboard.
// Guard checks are compiled in when STACK_GUARD_EN is defined.
module tb_mem_stack_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop;
  logic [15:0] ex_address, ex_write_data;
  logic        int_req;
  logic [15:0] int_pc;
  logic [2:0]  int_flags;
  logic        rti_req;
  logic [15:0] rd_data;
  logic        memory_read, memory_write, memory_push, memory_pop;
  logic [15:0] address, write_data;
  logic        stall, int_ack, rti_ack, restore_valid;
  logic [15:0] restore_pc;
  logic [2:0]  restore_flags;
  logic [10:0] stack_depth;
`ifdef STACK_GUARD_EN
  logic        stack_fault;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] pq[$];   // expected pushed words, in order
  logic [18:0] rq[$];   // expected {restore_pc, restore_flags}

  // Memory-stage stack model supplying rd_data
  logic [15:0] tb_mem [4096];
  int          tb_sp;

  always #5 clk = ~clk;

  mem_stack_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_push(ex_mem_push), .ex_mem_pop(ex_mem_pop),
    .ex_address(ex_address), .ex_write_data(ex_write_data),
    .int_req(int_req), .int_pc(int_pc), .int_flags(int_flags),
    .rti_req(rti_req), .rd_data(rd_data),
    .memory_read(memory_read), .memory_write(memory_write),
    .memory_push(memory_push), .memory_pop(memory_pop),
    .address(address), .write_data(write_data),
    .stall(stall), .int_ack(int_ack), .rti_ack(rti_ack),
    .restore_valid(restore_valid), .restore_pc(restore_pc),
    .restore_flags(restore_flags), .stack_depth(stack_depth)
`ifdef STACK_GUARD_EN
    , .stack_fault(stack_fault)
`endif
  );

  always_comb rd_data = (tb_sp > 0) ? tb_mem[tb_sp-1] : 16'hDEAD;

  always @(posedge clk) begin
    if (rst) tb_sp <= 0;
    else if (memory_push) begin
      tb_mem[tb_sp] <= write_data;
      tb_sp         <= tb_sp + 1;
    end else if (memory_pop && tb_sp > 0)
      tb_sp <= tb_sp - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Ends the current cycle: scoreboards pushes, crosses the edge, scoreboards restores.
  task automatic step();
    #1;
    if (memory_push) begin
      check("push_expected", 32'(pq.size() != 0), 1);
      if (pq.size() != 0) check("push_data", 32'(write_data), 32'(pq.pop_front()));
    end
    @(posedge clk);
    #1;
    if (restore_valid) begin
      check("restore_expected", 32'(rq.size() != 0), 1);
      if (rq.size() != 0) check("restore_data", 32'({restore_pc, restore_flags}), 32'(rq.pop_front()));
    end
  endtask

  initial begin
    rst = 1'b1;
    {ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop} = '0;
    ex_address = '0; ex_write_data = '0;
    int_req = 1'b0; int_pc = '0; int_flags = '0; rti_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 0);
    check("rst_depth", 32'(stack_depth), 0);
    check("rst_restore_valid", 32'(restore_valid), 0);
    check("rst_restore_pc", 32'(restore_pc), 0);
    check("rst_restore_flags", 32'(restore_flags), 0);
    check("rst_strobes", 32'({memory_read, memory_write, memory_push, memory_pop}), 0);
    rst = 1'b0;

    // Pipeline push passes through
    ex_mem_push = 1'b1; ex_write_data = 16'h1234; ex_address = 16'h7FF0;
    settle();
    check("pipe_push", 32'(memory_push), 1);
    check("pipe_push_data", 32'(write_data), 32'h1234);
    check("pipe_push_addr", 32'(address), 32'h7FF0);
    check("pipe_push_stall", 32'(stall), 0);
    pq.push_back(16'h1234);
    step();
    ex_mem_push = 1'b0;
    check("depth_after_push", 32'(stack_depth), 1);

    // Read+write both forwarded; push beats pop
    {ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop} = 4'b1111;
    ex_write_data = 16'hBEEF;
    settle();
    check("rw_push_pop_strobes", 32'({memory_read, memory_write, memory_push, memory_pop}), 32'b1110);
    pq.push_back(16'hBEEF);
    step();
    {ex_mem_read, ex_mem_write, ex_mem_push, ex_mem_pop} = 4'b0001;
    settle();
    check("pipe_pop", 32'(memory_pop), 1);
    check("depth_push_wins", 32'(stack_depth), 2);
    step();
    ex_mem_pop = 1'b0;
    check("depth_after_pop", 32'(stack_depth), 1);

    // Interrupt context save
    int_req = 1'b1; int_pc = 16'h00A0; int_flags = 3'b101;
    ex_mem_read = 1'b1; ex_address = 16'h0042;
    settle();
    check("int_c0_read_fwd", 32'(memory_read), 1);
    check("int_c0_addr", 32'(address), 32'h0042);
    check("int_c0_stall", 32'(stall), 0);
    step();
    int_pc = 16'hFFFF; int_flags = 3'b000;
    ex_mem_read = 1'b0; ex_mem_write = 1'b1;
    settle();
    check("int_c1_stall", 32'(stall), 1);
    check("int_c1_push", 32'(memory_push), 1);
    check("int_c1_ex_ignored", 32'(memory_write), 0);
    check("int_c1_addr", 32'(address), 0);
    check("int_c1_ack", 32'(int_ack), 0);
    pq.push_back(16'h00A0);
    step();
    settle();
    check("int_c2_stall", 32'(stall), 1);
    check("int_c2_ack", 32'(int_ack), 1);
    check("int_c2_push", 32'(memory_push), 1);
    pq.push_back(16'h0005);
    step();
    int_req = 1'b0; ex_mem_write = 1'b0;
    settle();
    check("int_c3_stall", 32'(stall), 0);
    check("int_c3_ack", 32'(int_ack), 0);
    check("int_depth", 32'(stack_depth), 3);

    // RTI restore
    rti_req = 1'b1; ex_mem_push = 1'b1; ex_write_data = 16'h5555;
    settle();
    check("rti_c0_no_fwd", 32'(memory_push), 0);
    check("rti_c0_stall", 32'(stall), 0);
    step();
    ex_mem_push = 1'b0;
    settle();
    check("rti_c1_stall", 32'(stall), 1);
    check("rti_c1_pop", 32'(memory_pop), 1);
    check("rti_c1_ack", 32'(rti_ack), 0);
    step();
    settle();
    check("rti_c2_pop", 32'(memory_pop), 1);
    check("rti_c2_ack", 32'(rti_ack), 1);
    check("rti_c2_valid", 32'(restore_valid), 0);
    rq.push_back({16'h00A0, 3'b101});
    step();
    rti_req = 1'b0;
    settle();
    check("rti_c3_valid", 32'(restore_valid), 1);
    check("rti_c3_pc", 32'(restore_pc), 32'h00A0);
    check("rti_c3_flags", 32'(restore_flags), 32'b101);
    check("rti_c3_stall", 32'(stall), 0);
    check("rti_depth", 32'(stack_depth), 1);
    step();
    check("rti_c4_valid", 32'(restore_valid), 0);

    // Simultaneous INT and RTI: INT first, then RTI
    int_req = 1'b1; rti_req = 1'b1; int_pc = 16'h0BCD; int_flags = 3'b010;
    ex_mem_write = 1'b1; ex_address = 16'h0100;
    settle();
    check("both_c0_write_fwd", 32'(memory_write), 1);
    check("both_c0_addr", 32'(address), 32'h0100);
    step();
    ex_mem_write = 1'b0;
    settle();
    check("both_c1_push", 32'(memory_push), 1);
    pq.push_back(16'h0BCD);
    step();
    settle();
    check("both_c2_int_ack", 32'(int_ack), 1);
    pq.push_back(16'h0002);
    step();
    int_req = 1'b0; ex_mem_read = 1'b1;
    settle();
    check("both_c3_no_fwd", 32'(memory_read), 0);
    check("both_c3_stall", 32'(stall), 0);
    check("both_c3_depth", 32'(stack_depth), 3);
    step();
    ex_mem_read = 1'b0;
    settle();
    check("both_c4_pop", 32'(memory_pop), 1);
    step();
    settle();
    check("both_c5_rti_ack", 32'(rti_ack), 1);
    rq.push_back({16'h0BCD, 3'b010});
    step();
    rti_req = 1'b0;
    check("both_c6_valid", 32'(restore_valid), 1);
    check("both_depth", 32'(stack_depth), 1);

    // Reset during PUSH_FLAGS
    int_req = 1'b1; int_pc = 16'h1111; int_flags = 3'b111;
    step();
    pq.push_back(16'h1111);
    step();
    settle();
    check("rstseq_in_flags", 32'(int_ack), 1);
    pq.push_back(16'h0007);
    rst = 1'b1; int_req = 1'b0;
    step();
    check("rstseq_stall", 32'(stall), 0);
    check("rstseq_depth", 32'(stack_depth), 0);
    check("rstseq_restore_pc", 32'(restore_pc), 0);
    check("rstseq_push", 32'(memory_push), 0);
    rst = 1'b0;

    // Pop at depth 0
    ex_mem_pop = 1'b1;
    settle();
`ifdef STACK_GUARD_EN
    check("under_pop_suppressed", 32'(memory_pop), 0);
    step();
    ex_mem_pop = 1'b0;
    check("under_fault", 32'(stack_fault), 1);
    check("under_depth", 32'(stack_depth), 0);
    step(); step();
    check("under_fault_sticky", 32'(stack_fault), 1);
`else
    check("under_pop_fwd", 32'(memory_pop), 1);
    step();
    ex_mem_pop = 1'b0;
    check("under_wrap", 32'(stack_depth), 32'h7FF);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("fill_start_depth", 32'(stack_depth), 0);
`ifdef STACK_GUARD_EN
    check("fault_cleared", 32'(stack_fault), 0);
`endif

    // Fill to STACK_DEPTH, then one more push
    ex_mem_push = 1'b1;
    for (int i = 0; i < 2047; i++) begin
      ex_write_data = 16'(i);
      pq.push_back(16'(i));
      step();
    end
    ex_write_data = 16'hF00D;
    settle();
    check("full_depth", 32'(stack_depth), 2047);
`ifdef STACK_GUARD_EN
    check("full_fault_before", 32'(stack_fault), 0);
    check("over_push_suppressed", 32'(memory_push), 0);
    step();
    check("over_fault", 32'(stack_fault), 1);
    check("over_depth", 32'(stack_depth), 2047);
`else
    check("over_push_fwd", 32'(memory_push), 1);
    pq.push_back(16'hF00D);
    step();
    check("over_wrap", 32'(stack_depth), 0);
`endif
    ex_mem_push = 1'b0;
    step();

    check("push_queue_drained", 32'(pq.size()), 0);
    check("restore_queue_drained", 32'(rq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
